fir_fifo_uart_tx: RTL and testbench
===================================

# fir_fifo_uart_tx

Drains the sample FIFO written by the FIR filter (via its write-enable/data outputs) and sends each 2*DATA_WIDTH-bit sample off-chip as UART 8N1 bytes, MSB byte first. Sits between the FIR output FIFO's read port and the board TX pin. It is the reader end of the filter's FIFO-write interface and provides the host-side data path for filtered samples.

## Interface
- DATA_WIDTH, 16, FIR input width; sample width is 2*DATA_WIDTH. Must be a multiple of 4.
- CLKS_PER_BIT, 104, clock cycles per UART bit. 104 gives 115200 baud at 12 MHz. Must be >= 2.
- i_clk  input  1  single system clock; all logic on its rising edge.
- i_rstn  input  1  reset; asynchronous assert, active-low.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rden  output  1  FIFO read strobe; one-cycle pulse per sample.
- i_fifo_data  input  2*DATA_WIDTH  FIFO read data; valid the cycle after o_fifo_rden.
- o_uart_tx  output  1  serial line; idles high.
- o_busy  output  1  high from the rden cycle through the last stop-bit cycle.
- o_sample_done  output  1  one-cycle pulse after the final stop bit of a sample.

## Operation
- NBYTES = 2*DATA_WIDTH/8, which is 4 at the default width.
- States:
  - IDLE: if i_fifo_empty=0, go to READ.
  - READ: o_fifo_rden=1, go to LATCH.
  - LATCH: capture i_fifo_data into the shift register, set byte index 0, go to START.
  - START: drive tx=0.
  - DATA: drive bits 0..7 of the current byte, LSB first.
  - STOP: drive tx=1.
  - After STOP: if more bytes remain, go to START for the next byte, back-to-back with no idle gap. After the last byte, pulse o_sample_done and go to IDLE.
- Byte order is MSB byte first: byte k = sample[2*DATA_WIDTH-1-8k -: 8]. Data is treated as raw bits; no sign handling.
- A bit counter counts 0..CLKS_PER_BIT-1; width is $clog2(CLKS_PER_BIT). Every START, DATA and STOP bit lasts exactly CLKS_PER_BIT cycles.
- i_fifo_empty is sampled only in IDLE; it is ignored while busy.
- Only one FIFO read is ever outstanding. There is no read-ahead.
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- Reset values: o_uart_tx=1, o_fifo_rden=0, o_busy=0, o_sample_done=0, state IDLE, counters 0.
- Reset mid-operation: outputs go to reset values immediately and asynchronously. The sample in flight is discarded and is not re-read. After release, the block restarts from IDLE.

## Timing
- Cycle 0: IDLE sees i_fifo_empty=0.
- Cycle 1: o_fifo_rden=1 and o_busy rises.
- Cycle 2: data is latched.
- Cycle 3: o_uart_tx falls (start bit).
- Frame length is NBYTES*10*CLKS_PER_BIT cycles, from the cycle the start bit begins to the end of the final stop bit.
- o_sample_done=1 and o_busy=0 in the first cycle after the final stop bit.
- Minimum line-high gap between consecutive samples is 3 cycles: IDLE, READ and LATCH after the stop bit. This gives a sustained rate of 1 sample per (NBYTES*10*CLKS_PER_BIT + 3) cycles. The writer must throttle, or rely on FIFO depth; overflow is the FIFO's concern.
- o_fifo_rden never asserts while i_fifo_empty=1 was sampled in the preceding IDLE cycle.

## Test plan
- Single sample. FIFO holds 0x12345678, CLKS_PER_BIT=4.
  - o_fifo_rden pulses once at cycle 1; tx falls at cycle 3.
  - Line decodes to bytes 0x12, 0x34, 0x56, 0x78, each 0,LSB..MSB,1.
  - o_sample_done pulses at cycle 163.
- Empty FIFO held for 1000 cycles: tx stays 1; o_fifo_rden, o_busy and o_sample_done all stay 0.
- Two samples 0xFFFF8000 then 0x00000001 queued:
  - exactly two rden pulses;
  - exactly 3 idle-high cycles between the first sample's final stop bit and the second start bit;
  - bytes received are FF FF 80 00 00 00 00 01.
- Asynchronous reset asserted mid-way through the DATA bit of byte 2:
  - tx goes to 1 and o_busy to 0 in the same cycle;
  - after release, the next FIFO word is read fresh, with no partial bytes resent.
- CLKS_PER_BIT=104: measured low time of the start bit is exactly 104 cycles, and every bit boundary lands at a multiple of 104 from the start edge.
- i_fifo_empty toggles during transmission: no extra o_fifo_rden pulses occur until o_sample_done has pulsed and the block is back in IDLE.

Source files
------------

// File: rtl/fir_fifo_uart_tx.sv
// fir_fifo_uart_tx: reader end of the FIR output FIFO. Pops one sample at a time
// and sends it on the TX pin as UART 8N1 bytes, MSB byte first, LSB bit first.
module fir_fifo_uart_tx #(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_rden,
    input  logic [2*DATA_WIDTH-1:0] i_fifo_data,
    output logic                    o_uart_tx,
    output logic                    o_busy,
    output logic                    o_sample_done
);

    localparam int SAMPLE_W = 2 * DATA_WIDTH;
    localparam int NBYTES   = SAMPLE_W / 8;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] shift_reg;
    logic [CNT_W-1:0]    clk_cnt;
    logic [2:0]          bit_idx;
    logic [IDX_W-1:0]    byte_idx;

    logic [7:0] cur_byte;
    logic [2:0] next_bit;
    logic       bit_end;

    // The byte on the wire is always the top byte; the register shifts left by
    // a byte after each stop bit so the next byte moves into place.
    assign cur_byte = shift_reg[SAMPLE_W-1 -: 8];
    assign next_bit = bit_idx + 3'd1;
    assign bit_end  = (clk_cnt == CNT_LAST);

    // Read/serialise sequencer; every output is a register updated on the
    // transition into the cycle where it must be visible.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= S_IDLE;
            shift_reg     <= '0;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            o_fifo_rden   <= 1'b0;
            o_uart_tx     <= 1'b1;
            o_busy        <= 1'b0;
            o_sample_done <= 1'b0;
        end else begin
            o_fifo_rden   <= 1'b0;
            o_sample_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!i_fifo_empty) begin
                        state       <= S_READ;
                        o_fifo_rden <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    shift_reg <= i_fifo_data;
                    byte_idx  <= '0;
                    clk_cnt   <= '0;
                    o_uart_tx <= 1'b0;
                    state     <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        o_uart_tx <= cur_byte[0];
                        state     <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            state     <= S_STOP;
                        end else begin
                            bit_idx   <= next_bit;
                            o_uart_tx <= cur_byte[next_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            o_busy        <= 1'b0;
                            o_sample_done <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            byte_idx  <= byte_idx + IDX_W'(1);
                            shift_reg <= shift_reg << 8;
                            o_uart_tx <= 1'b0;
                            state     <= S_START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_fifo_uart_tx.sv
// tb_fir_fifo_uart_tx: drives two instances (4 and 104 clocks per bit) from
// small FIFO models and decodes their serial lines with an independent receiver.
module tb_fir_fifo_uart_tx;

    localparam int CPB0 = 4;
    localparam int CPB1 = 104;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc  = 0;

    logic        empty0, rden0, tx0, busy0, done0;
    logic [31:0] data0 = '0;
    logic        empty1, rden1, tx1, busy1, done1;
    logic [31:0] data1 = '0;

    fir_fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB0)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_fifo_empty  (empty0),
        .o_fifo_rden   (rden0),
        .i_fifo_data   (data0),
        .o_uart_tx     (tx0),
        .o_busy        (busy0),
        .o_sample_done (done0)
    );

    fir_fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB1)) dut104 (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_fifo_empty  (empty1),
        .o_fifo_rden   (rden1),
        .i_fifo_data   (data1),
        .o_uart_tx     (tx1),
        .o_busy        (busy1),
        .o_sample_done (done1)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model for the fast instance: word appears on data0 the cycle after rden0.
    logic [31:0] mem0 [0:255];
    int   wrPtr0     = 0;
    int   rdPtr0     = 0;
    logic emptyForce = 1'b0;
    assign empty0 = (wrPtr0 == rdPtr0) || emptyForce;
    always @(posedge clk) begin
        if (rden0) begin
            data0  <= mem0[rdPtr0[7:0]];
            rdPtr0 <= rdPtr0 + 1;
        end
    end

    // One-deep FIFO model for the 104-clock instance.
    logic [31:0] word1 = '0;
    int pushCnt1 = 0;
    int popCnt1  = 0;
    assign empty1 = (pushCnt1 == popCnt1);
    always @(posedge clk) begin
        if (rden1) begin
            data1   <= word1;
            popCnt1 <= popCnt1 + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    int   rdenCnt0 = 0, doneCnt0 = 0, doneCnt1 = 0;
    int   lastDone0 = 0, lastDone1 = 0, rdenAtDone0 = 0;
    int   frameStart0 = 0, gap0 = -1;
    int   rdenBad = 0, activeCnt0 = 0;
    int   frameErr = 0, boundaryErr = 0;
    int   fallCyc1 = 0, lowLen1 = -1;
    logic afterDone0   = 1'b1;
    logic emptyAtEdge0 = 1'b1;
    int   bitLen [2]  = '{CPB0, CPB1};
    int   rxPhase [2] = '{-1, -1};
    logic txPrev [2]  = '{1'b1, 1'b1};
    logic [7:0] rxSh [2];
    logic [7:0] rxQ0 [$];
    logic [7:0] rxQ1 [$];
    logic [31:0] expW [$];

    // Remember what the DUT saw on the empty flag at each rising edge.
    always @(posedge clk) emptyAtEdge0 = empty0;

    // Event counters and a mid-bit sampling UART receiver for both lines.
    always @(negedge clk) begin
        logic cur;
        int   bitNo;
        if (rden0) begin
            rdenCnt0++;
            if (emptyAtEdge0) rdenBad++;
        end
        if (done0) begin
            doneCnt0++;
            lastDone0   = cyc;
            rdenAtDone0 = rdenCnt0;
            afterDone0  = 1'b1;
        end
        if (done1) begin
            doneCnt1++;
            lastDone1 = cyc;
        end
        if (!tx0 || busy0 || rden0 || done0) activeCnt0++;
        if (!rstn) afterDone0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cur = (k == 0) ? tx0 : tx1;
            if (!rstn) begin
                rxPhase[k] = -1;
            end else begin
                if (rxPhase[k] >= 0) begin
                    rxPhase[k]++;
                    if (cur != txPrev[k] && (rxPhase[k] % bitLen[k]) != 0) boundaryErr++;
                end else if (!cur && txPrev[k]) begin
                    rxPhase[k] = 0;
                    if (k == 0 && afterDone0) begin
                        frameStart0 = cyc;
                        gap0        = cyc - lastDone0;
                        afterDone0  = 1'b0;
                    end
                    if (k == 1) fallCyc1 = cyc;
                end
                if (k == 1 && cur && !txPrev[1] && lowLen1 < 0) lowLen1 = cyc - fallCyc1;
                if (rxPhase[k] >= 0 && (rxPhase[k] % bitLen[k]) == bitLen[k] / 2) begin
                    bitNo = rxPhase[k] / bitLen[k];
                    if (bitNo == 0) begin
                        if (cur) frameErr++;
                    end else if (bitNo <= 8) begin
                        rxSh[k][3'(bitNo - 1)] = cur;
                    end else begin
                        if (!cur) frameErr++;
                        if (k == 0) rxQ0.push_back(rxSh[0]);
                        else        rxQ1.push_back(rxSh[1]);
                        rxPhase[k] = -1;
                    end
                end
            end
            txPrev[k] = cur;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue a word into the fast instance's FIFO and into the expected list.
    task automatic applyStimulus(input logic [31:0] w);
        mem0[wrPtr0[7:0]] = w;
        wrPtr0++;
        expW.push_back(w);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic waitRel(input int c0, input int n);
        while (cyc - c0 < n) stepCycles(1);
    endtask

    task automatic waitDone0(input int target, input int budget);
        int n = 0;
        while (doneCnt0 < target && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput("done0_reached", 64'(doneCnt0 >= target), 64'd1);
        stepCycles(2);
    endtask

    // Compare received bytes against the expected words, MSB byte first.
    task automatic checkRx0(input string tag);
        logic [31:0] got;
        checkOutput({tag, "_nbytes"}, 64'(rxQ0.size()), 64'(expW.size() * 4));
        for (int i = 0; i < expW.size(); i++) begin
            got = '0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < rxQ0.size()) got = {got[23:0], rxQ0[4 * i + j]};
            checkOutput(tag, 64'(got), 64'(expW[i]));
        end
        rxQ0.delete();
        expW.delete();
    endtask

    initial begin
        int c0, r0, a0, d0, rb, firstRdens;
        logic [31:0] got1;

        #1 rstn = 1'b0;
        stepCycles(3);
        checkOutput("reset_outs0", 64'({tx0, rden0, busy0, done0}), 64'b1000);
        checkOutput("reset_outs1", 64'({tx1, rden1, busy1, done1}), 64'b1000);
        rstn = 1'b1;
        stepCycles(3);

        $display("[TB] single sample 0x12345678");
        c0 = cyc;
        r0 = rdenCnt0;
        applyStimulus(32'h12345678);
        waitRel(c0, 1);
        checkOutput("rden_c1", 64'({rden0, busy0}), 64'b11);
        waitRel(c0, 2);
        checkOutput("rden_c2", 64'(rden0), 64'd0);
        waitRel(c0, 3);
        checkOutput("tx_start_c3", 64'(tx0), 64'd0);
        waitRel(c0, 162);
        checkOutput("last_stop_c162", 64'({tx0, busy0, done0}), 64'b110);
        waitRel(c0, 163);
        checkOutput("done_c163", 64'({tx0, busy0, done0}), 64'b101);
        waitRel(c0, 164);
        checkOutput("done_c164", 64'(done0), 64'd0);
        stepCycles(5);
        checkOutput("rden_once", 64'(rdenCnt0 - r0), 64'd1);
        checkOutput("frame_start", 64'(frameStart0 - c0), 64'd3);
        checkRx0("single_bytes");

        $display("[TB] empty FIFO for 1000 cycles");
        r0 = rdenCnt0;
        a0 = activeCnt0;
        d0 = doneCnt0;
        stepCycles(1000);
        checkOutput("idle_active", 64'(activeCnt0 - a0), 64'd0);
        checkOutput("idle_rden", 64'(rdenCnt0 - r0), 64'd0);
        checkOutput("idle_done", 64'(doneCnt0 - d0), 64'd0);
        checkOutput("idle_tx", 64'(tx0), 64'd1);

        $display("[TB] two queued samples");
        r0 = rdenCnt0;
        d0 = doneCnt0;
        applyStimulus(32'hFFFF8000);
        applyStimulus(32'h00000001);
        waitDone0(d0 + 2, 600);
        checkOutput("two_rden", 64'(rdenCnt0 - r0), 64'd2);
        checkOutput("two_gap", 64'(gap0), 64'd3);
        checkRx0("two_bytes");

        $display("[TB] reset during byte 2 data");
        stepCycles(5);
        c0 = cyc;
        applyStimulus(32'hCAFE10BE);
        waitRel(c0, 99);
        checkOutput("pre_reset", 64'({tx0, busy0}), 64'b01);
        rstn = 1'b0;
        #1;
        checkOutput("async_reset", 64'({tx0, busy0, rden0, done0}), 64'b1000);
        stepCycles(3);
        rstn = 1'b1;
        r0 = rdenCnt0;
        stepCycles(20);
        checkOutput("no_reread", 64'(rdenCnt0 - r0), 64'd0);
        got1 = '0;
        if (rxQ0.size() >= 2) got1 = {16'h0, rxQ0[0], rxQ0[1]};
        checkOutput("partial_count", 64'(rxQ0.size()), 64'd2);
        checkOutput("partial_bytes", 64'(got1), 64'h0000CAFE);
        rxQ0.delete();
        expW.delete();
        d0 = doneCnt0;
        applyStimulus(32'h0F1E2D3C);
        waitDone0(d0 + 1, 300);
        checkOutput("fresh_rden", 64'(rdenCnt0 - r0), 64'd1);
        checkRx0("fresh_bytes");

        $display("[TB] 104 clocks per bit");
        c0 = cyc;
        word1 = 32'hA5C30181;
        pushCnt1++;
        d0 = doneCnt1;
        begin
            int n = 0;
            while (doneCnt1 == d0 && n < 5000) begin
                stepCycles(1);
                n++;
            end
        end
        stepCycles(2);
        checkOutput("slow_start_low", 64'(lowLen1), 64'(CPB1));
        checkOutput("slow_done_cycle", 64'(lastDone1 - c0), 64'(3 + 40 * CPB1));
        got1 = '0;
        for (int j = 0; j < 4; j++)
            if (j < rxQ1.size()) got1 = {got1[23:0], rxQ1[j]};
        checkOutput("slow_nbytes", 64'(rxQ1.size()), 64'd4);
        checkOutput("slow_bytes", 64'(got1), 64'hA5C30181);

        $display("[TB] empty flag toggling while busy");
        r0 = rdenCnt0;
        d0 = doneCnt0;
        applyStimulus(32'h5A3C_96E1);
        begin
            int n = 0;
            while (doneCnt0 == d0 && n < 600) begin
                emptyForce = 1'($urandom_range(0, 1));
                if (n == 50) applyStimulus(32'h0BAD_F00D);
                stepCycles(1);
                n++;
            end
        end
        firstRdens = rdenAtDone0 - r0;
        emptyForce = 1'b0;
        checkOutput("toggle_rden_first", 64'(firstRdens), 64'd1);
        waitDone0(d0 + 2, 600);
        checkOutput("toggle_rden_total", 64'(rdenCnt0 - r0), 64'd2);
        checkRx0("toggle_bytes");

        $display("[TB] random samples");
        r0 = rdenCnt0;
        d0 = doneCnt0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom);
            stepCycles($urandom_range(0, 250));
        end
        waitDone0(d0 + 6, 1500);
        checkOutput("rand_rden", 64'(rdenCnt0 - r0), 64'd6);
        checkRx0("rand_bytes");

        rb = rdenBad;
        checkOutput("rden_while_empty", 64'(rb), 64'd0);
        checkOutput("framing", 64'(frameErr), 64'd0);
        checkOutput("bit_boundaries", 64'(boundaryErr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
